// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_master
//  Description : Host-side JTAG initiator. Turns single commands (TAP reset,
//                IR shift, DR shift, idle clocking) into TMS walks plus a
//                bit-serial TDI shift, and returns the captured TDO word.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    // Command codes
    localparam logic [1:0] c_op_reset = 2'd0;
    localparam logic [1:0] c_op_ir    = 2'd1;
    localparam logic [1:0] c_op_dr    = 2'd2;
    localparam logic [1:0] c_op_idle  = 2'd3;

    // FSM states; the state names the segment of the next TCK to be started
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_pre   = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_post  = 2'd3;

    // TCK phase points inside one 2*CLK_DIV period
    localparam logic [8:0] c_half = 9'(CLK_DIV);
    localparam logic [8:0] c_last = 9'(2 * CLK_DIV - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_op;
    logic [5:0]  r_len;
    logic [31:0] r_data;
    logic [5:0]  r_cnt;
    logic [8:0]  r_phase;
    logic [31:0] r_cap;
    logic        r_cap_en;
    logic [4:0]  r_cap_idx;
    logic        r_tck;
    logic        r_tms;
    logic        r_tdi;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;

    logic [5:0]  w_len_clamped;
    logic [5:0]  w_pre_len;
    logic [5:0]  w_post_len;
    logic        w_tms;
    logic        w_seg_last;
    logic [1:0]  w_next_state;
    logic        w_done;
    logic        w_is_shift_op;

    // Effective length: 0 becomes 1, anything above 32 becomes 32
    always_comb begin
        w_len_clamped = cmd_len;
        if (cmd_len == 6'd0) begin
            w_len_clamped = 6'd1;
        end else if (cmd_len > 6'd32) begin
            w_len_clamped = 6'd32;
        end
    end

    // Per-command segment lengths (TCK counts in PRE and POST)
    always_comb begin
        w_pre_len  = 6'd1;
        w_post_len = 6'd0;
        case (r_op)
            c_op_reset: begin w_pre_len = 6'd5; w_post_len = 6'd1; end
            c_op_ir:    begin w_pre_len = 6'd4; w_post_len = 6'd2; end
            c_op_dr:    begin w_pre_len = 6'd3; w_post_len = 6'd2; end
            default:    begin w_pre_len = 6'd1; w_post_len = r_len - 6'd1; end
        endcase
    end

    assign w_is_shift_op = (r_op == c_op_ir) || (r_op == c_op_dr);
    assign w_done        = (r_state == c_st_post) && (r_cnt == w_post_len);

    // TMS for the TCK about to start, and where the walk goes next
    always_comb begin
        w_tms        = 1'b0;
        w_seg_last   = 1'b0;
        w_next_state = r_state;
        case (r_state)
            c_st_pre: begin
                case (r_op)
                    c_op_reset: w_tms = 1'b1;
                    c_op_ir:    w_tms = (r_cnt < 6'd2);
                    c_op_dr:    w_tms = (r_cnt == 6'd0);
                    default:    w_tms = 1'b0;
                endcase
                w_seg_last   = (r_cnt == w_pre_len - 6'd1);
                w_next_state = w_is_shift_op ? c_st_shift : c_st_post;
            end
            c_st_shift: begin
                w_tms        = (r_cnt == r_len - 6'd1);
                w_seg_last   = (r_cnt == r_len - 6'd1);
                w_next_state = c_st_post;
            end
            c_st_post: begin
                w_tms = w_is_shift_op && (r_cnt == 6'd0);
            end
            default: begin
                w_tms = 1'b0;
            end
        endcase
    end

    // Command FSM, TCK phase generator, TMS/TDI drive and TDO capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_op        <= c_op_reset;
            r_len       <= 6'd0;
            r_data      <= 32'd0;
            r_cnt       <= 6'd0;
            r_phase     <= 9'd0;
            r_cap       <= 32'd0;
            r_cap_en    <= 1'b0;
            r_cap_idx   <= 5'd0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_state == c_st_idle) begin
                if (cmd_valid) begin
                    r_op     <= cmd_op;
                    r_len    <= w_len_clamped;
                    r_data   <= cmd_data;
                    r_cnt    <= 6'd0;
                    r_phase  <= 9'd0;
                    r_cap    <= 32'd0;
                    r_cap_en <= 1'b0;
                    r_state  <= c_st_pre;
                end
            end else begin
                r_phase <= (r_phase == c_last) ? 9'd0 : r_phase + 9'd1;
                if (r_phase == 9'd0) begin
                    // Falling edge: finish, or launch the next TCK
                    r_tck <= 1'b0;
                    if (w_done) begin
                        r_state     <= c_st_idle;
                        r_cnt       <= 6'd0;
                        r_phase     <= 9'd0;
                        r_cap_en    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_cap;
                    end else begin
                        r_tms     <= w_tms;
                        r_tdi     <= (r_state == c_st_shift) ? r_data[r_cnt[4:0]] : 1'b0;
                        r_cap_en  <= (r_state == c_st_shift);
                        r_cap_idx <= r_cnt[4:0];
                        if (w_seg_last && (r_state != c_st_post)) begin
                            r_state <= w_next_state;
                            r_cnt   <= 6'd0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end else if (r_phase == c_half) begin
                    // Rising edge: TDO is sampled together with TCK going high
                    r_tck <= 1'b1;
                    if (r_cap_en) begin
                        r_cap[r_cap_idx] <= tdo;
                    end
                end
            end
        end
    end

    assign cmd_ready = (r_state == c_st_idle) && !reset;
    assign busy      = (r_state != c_st_idle);
    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_master
//  Description : Self-checking bench for jtag_master (CLK_DIV = 2). Directed
//                vector table, randomized commands against a sequence model,
//                plus reset-abort and back-to-back sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_master;

    localparam int c_div = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;

    jtag_master #(.CLK_DIV(c_div)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // TDO source: 0 = tied 0, 1 = tied 1, 2 = loopback of TDI, 3 = random
    int tdo_mode = 0;
    bit r_loop   = 1'b0;
    bit r_rand   = 1'b0;
    assign tdo = (tdo_mode == 0) ? 1'b0 :
                 (tdo_mode == 1) ? 1'b1 :
                 (tdo_mode == 2) ? r_loop : r_rand;

    // Target side changes TDO just after TCK falls
    always @(negedge tck) begin
        #1;
        r_loop = tdi;
        r_rand = 1'($urandom_range(0, 1));
    end

    // What the target sees on every TCK rising edge
    bit obs_tms[$];
    bit obs_tdi[$];
    bit obs_tdo[$];
    always @(posedge tck) begin
        obs_tms.push_back(tms);
        obs_tdi.push_back(tdi);
        obs_tdo.push_back(tdo);
    end

    task automatic clear_obs();
        obs_tms.delete();
        obs_tdi.delete();
        obs_tdo.delete();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected TCK-by-TCK TMS/TDI streams for one command
    task automatic model(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         output int t, output int sh_start, output int l,
                         output logic [63:0] etms, output logic [63:0] etdi);
        bit q[$];
        l = (len == 0) ? 1 : (len > 32) ? 32 : int'(len);
        sh_start = -1;
        case (op)
            2'd0: begin
                repeat (5) q.push_back(1'b1);
                q.push_back(1'b0);
            end
            2'd1, 2'd2: begin
                q.push_back(1'b1);
                if (op == 2'd1) q.push_back(1'b1);
                q.push_back(1'b0);
                q.push_back(1'b0);
                sh_start = q.size();
                for (int i = 0; i < l; i++) q.push_back(i == l - 1);
                q.push_back(1'b1);
                q.push_back(1'b0);
            end
            default: begin
                for (int i = 0; i < l; i++) q.push_back(1'b0);
            end
        endcase
        t    = q.size();
        etms = '0;
        etdi = '0;
        for (int i = 0; i < t; i++) etms[i] = q[i];
        if (sh_start >= 0)
            for (int i = 0; i < l; i++) etdi[sh_start + i] = data[i];
    endtask

    task automatic pack_obs(input int base, output logic [63:0] atms, output logic [63:0] atdi);
        atms = '0;
        atdi = '0;
        for (int i = base; i < obs_tms.size() && (i - base) < 64; i++) begin
            atms[i - base] = obs_tms[i];
            atdi[i - base] = obs_tdi[i];
        end
    endtask

    // Waits for rsp_valid; returns cycles since accept and count of cycles
    // where busy/cmd_ready looked wrong before the response
    task automatic wait_rsp(output int n, output int bad);
        bit seen = 1'b0;
        n   = 0;
        bad = 0;
        while (!seen && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            if (rsp_valid) seen = 1'b1;
            else if (!busy || cmd_ready) bad++;
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                           input string tag, output logic [31:0] rsp);
        int t, ss, l, n, bad;
        logic [63:0] etms, etdi, atms, atdi;
        logic [31:0] ersp;
        model(op, len, data, t, ss, l, etms, etdi);
        clear_obs();
        check({tag, "_ready_before"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = 6'($urandom);
        cmd_data  = $urandom;
        check({tag, "_busy_after_accept"}, busy, 1);
        wait_rsp(n, bad);
        check({tag, "_latency"}, n, 1 + t * 2 * c_div);
        check({tag, "_busy_window"}, bad, 0);
        check({tag, "_tck_low_at_rsp"}, tck, 0);
        check({tag, "_ready_at_rsp"}, cmd_ready, 1);
        check({tag, "_tck_count"}, obs_tms.size(), t);
        pack_obs(0, atms, atdi);
        check({tag, "_tms_seq"}, atms, etms);
        check({tag, "_tdi_seq"}, atdi, etdi);
        ersp = '0;
        if (ss >= 0)
            for (int i = 0; i < l && (ss + i) < obs_tdo.size(); i++) ersp[i] = obs_tdo[ss + i];
        check({tag, "_rsp_model"}, rsp_data, ersp);
        rsp = rsp_data;
        @(posedge clk);
        #1;
        check({tag, "_rsp_pulse"}, rsp_valid, 0);
        check({tag, "_rsp_hold"}, rsp_data, rsp);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        int          mode;
        logic [31:0] exp_rsp;
        int          exp_tcks;
    } vec_t;

    vec_t vt[8];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rsp;
        int n, bad, t1, t2, ss, l;
        logic [63:0] e1tms, e1tdi, e2tms, e2tdi, atms, atdi;

        vt[0] = '{2'd0, 6'd0,  32'hFFFF_FFFF, 3, 32'h0000_0000, 6};
        vt[1] = '{2'd2, 6'd32, 32'hA5A5_1234, 2, 32'hA5A5_1234, 37};
        vt[2] = '{2'd1, 6'd4,  32'h0000_0002, 1, 32'h0000_000F, 10};
        vt[3] = '{2'd3, 6'd0,  32'hDEAD_BEEF, 1, 32'h0000_0000, 1};
        vt[4] = '{2'd2, 6'd40, 32'h3C3C_9001, 2, 32'h3C3C_9001, 37};
        vt[5] = '{2'd1, 6'd1,  32'h0000_0001, 1, 32'h0000_0001, 7};
        vt[6] = '{2'd2, 6'd5,  32'h0000_001F, 0, 32'h0000_0000, 10};
        vt[7] = '{2'd3, 6'd63, 32'h1234_5678, 1, 32'h0000_0000, 32};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_len   = 6'd0;
        cmd_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tck", tck, 0);
        check("reset_tms", tms, 1);
        check("reset_tdi", tdi, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_ready_low_in_reset", cmd_ready, 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", cmd_ready, 1);
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            tdo_mode = vt[i].mode;
            run_cmd(vt[i].op, vt[i].len, vt[i].data, $sformatf("vec%0d", i), rsp);
            check($sformatf("vec%0d_rsp", i), rsp, vt[i].exp_rsp);
            check($sformatf("vec%0d_tcks", i), obs_tms.size(), vt[i].exp_tcks);
        end

        // Randomized commands with random TDO
        tdo_mode = 3;
        for (int i = 0; i < 24; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), $urandom,
                    $sformatf("rnd%0d", i), rsp);
        end

        // Reset in the middle of a DR shift
        tdo_mode = 2;
        run_cmd(2'd2, 6'd8, 32'h0000_00A5, "pre_abort", rsp);
        check("pre_abort_rsp", rsp, 32'h0000_00A5);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = 6'd32;
        cmd_data  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_tck", tck, 0);
        check("abort_tms", tms, 1);
        check("abort_tdi", tdi, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_data", rsp_data, 0);
        check("abort_ready", cmd_ready, 1);
        clear_obs();
        n = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (rsp_valid) n++;
        end
        check("abort_no_rsp", n, 0);
        check("abort_no_tck", obs_tms.size(), 0);
        tdo_mode = 1;
        run_cmd(2'd0, 6'd0, 32'd0, "recover", rsp);

        // Back-to-back: second command waits on cmd_valid during the first
        model(2'd1, 6'd2, 32'h1, t1, ss, l, e1tms, e1tdi);
        model(2'd3, 6'd2, 32'h0, t2, ss, l, e2tms, e2tdi);
        clear_obs();
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_len   = 6'd2;
        cmd_data  = 32'h1;
        @(posedge clk);
        #1;
        cmd_op    = 2'd3;
        cmd_len   = 6'd2;
        cmd_data  = 32'hFFFF_FFFF;
        wait_rsp(n, bad);
        check("b2b_first_latency", n, 1 + t1 * 2 * c_div);
        check("b2b_ready_low_first", bad, 0);
        check("b2b_ready_at_rsp", cmd_ready, 1);
        check("b2b_first_rsp", rsp_data, 32'h3);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("b2b_second_accepted", busy, 1);
        wait_rsp(n, bad);
        check("b2b_second_latency", n, 1 + t2 * 2 * c_div);
        check("b2b_second_rsp", rsp_data, 0);
        check("b2b_tck_count", obs_tms.size(), t1 + t2);
        pack_obs(0, atms, atdi);
        check("b2b_tms_seq", atms, e1tms | (e2tms << t1));
        check("b2b_tdi_seq", atdi, e1tdi | (e2tdi << t1));

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
